gpio_input_conditioner: RTL and testbench

- Parametrised input front-end between the board switches/buttons and the MicroBlaze GPIO input channels.
- For every channel it synchronises the raw pin, applies optional active-low inversion, and debounces with a per-channel stability counter.
- It latches rising and falling edges of the debounced level into sticky pending bits, which software clears through a write-one-to-clear port.
- It raises a single interrupt line while any pending bit is set, replacing the direct wiring of switches and buttons into the block design.

---
 rtl/gpio_cond_pkg.sv | 13 +
 rtl/gpio_input_conditioner_debounce_channel.sv | 101 ++++++++++
 rtl/gpio_input_conditioner.sv | 41 ++++
 tb/tb_gpio_input_conditioner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cond_pkg.sv
// Shared constants for the GPIO input conditioner: the system clock rate and
// the default debounce time, plus a helper that turns milliseconds into cycles.
package gpio_cond_pkg;

    localparam int CLK_HZ      = 32'd100_000_000;
    localparam int DEBOUNCE_MS = 32'd10;

    // Number of clock cycles in the given number of milliseconds.
    function automatic int debounce_cycles(input int ms);
        return (CLK_HZ / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/gpio_input_conditioner_debounce_channel.sv
// One input channel: synchroniser, optional inversion, stability-counter
// debounce and sticky rise/fall pending bits with write-one-to-clear.
module debounce_channel
    import gpio_cond_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 8,
    parameter logic INVERT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    input  logic clr,
    output logic level,
    output logic rise_pending,
    output logic fall_pending
);

    // The counter only needs to reach DEBOUNCE_CYCLES-1, and is never narrower than one bit.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   cond_s;
    logic                   stable_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   commit_s;
    logic                   stable_next_s;
    logic [CNT_W-1:0]       cnt_next_s;
    logic                   rise_next_s;
    logic                   fall_next_s;

    // Shift the asynchronous pin through the synchroniser chain; only stage 0 sees raw_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign cond_s = sync_r[SYNC_STAGES-1] ^ INVERT;

    // Debounce decision: count consecutive disagreeing cycles, commit after the full window.
    always_comb begin
        commit_s      = 1'b0;
        stable_next_s = stable_r;
        cnt_next_s    = cnt_r;
        if (cond_s == stable_r) begin
            cnt_next_s = '0;
        end else if (cnt_r == CNT_LAST) begin
            commit_s      = 1'b1;
            stable_next_s = cond_s;
            cnt_next_s    = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Pending bits: a clear drops both, but a commit in the same cycle still sets its own bit.
    always_comb begin
        rise_next_s = rise_r;
        fall_next_s = fall_r;
        if (commit_s && cond_s) begin
            rise_next_s = 1'b1;
        end else if (clr) begin
            rise_next_s = 1'b0;
        end else begin
            rise_next_s = rise_r;
        end
        if (commit_s && !cond_s) begin
            fall_next_s = 1'b1;
        end else if (clr) begin
            fall_next_s = 1'b0;
        end else begin
            fall_next_s = fall_r;
        end
    end

    // Register the debounced level, the count and the sticky edge bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_r <= 1'b0;
            cnt_r    <= '0;
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
        end else begin
            stable_r <= stable_next_s;
            cnt_r    <= cnt_next_s;
            rise_r   <= rise_next_s;
            fall_r   <= fall_next_s;
        end
    end

    assign level        = stable_r;
    assign rise_pending = rise_r;
    assign fall_pending = fall_r;

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input front-end: NUM_CH debounced channels with sticky edge flags and a
// single interrupt line that is high while any edge flag is pending.
module gpio_input_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int                NUM_CH          = 20,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = debounce_cycles(DEBOUNCE_MS),
    parameter logic [NUM_CH-1:0] INVERT_MASK     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] level_out,
    output logic [NUM_CH-1:0] rise_pending,
    output logic [NUM_CH-1:0] fall_pending,
    input  logic              clr_valid,
    input  logic [NUM_CH-1:0] clr_mask,
    output logic              irq
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT_MASK[i])
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .raw_in       (raw_in[i]),
            .clr          (clr_valid & clr_mask[i]),
            .level        (level_out[i]),
            .rise_pending (rise_pending[i]),
            .fall_pending (fall_pending[i])
        );
    end

    // Interrupt is decoded from pending flops only, so raw pin activity cannot glitch it.
    assign irq = |(rise_pending | fall_pending);

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner (4 channels, 2 sync stages,
// 8-cycle debounce, channel 3 active-low): directed table, hand-written corner
// sequences, and a randomized run against a history-window reference model.
module tb_gpio_input_conditioner;

    localparam int         NCH = 4;
    localparam int         SS  = 2;
    localparam int         DC  = 8;
    localparam logic [3:0] INV = 4'b1000;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   raw_in;
    logic [NCH-1:0]   level_out;
    logic [NCH-1:0]   rise_pending;
    logic [NCH-1:0]   fall_pending;
    logic             clr_valid;
    logic [NCH-1:0]   clr_mask;
    logic             irq;

    gpio_input_conditioner #(
        .NUM_CH          (NCH),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .INVERT_MASK     (INV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_in       (raw_in),
        .level_out    (level_out),
        .rise_pending (rise_pending),
        .fall_pending (fall_pending),
        .clr_valid    (clr_valid),
        .clr_mask     (clr_mask),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        logic       rst;
        logic       cv;
        logic [3:0] cm;
        int         n;
        logic       each;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       irq;
    } vec_t;

    vec_t vecs[9];
    int   errors = 0;
    int   checks = 0;

    // Reference model: raw samples delayed through a queue, and a history of
    // conditioned values; a channel commits when its last DC samples all
    // disagree with its current level.
    logic [3:0] q_raw[$];
    logic [3:0] q_c[$];
    logic [3:0] m_lvl  = 4'b0000;
    logic [3:0] m_rise = 4'b0000;
    logic [3:0] m_fall = 4'b0000;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] c;
        logic [3:0] e;
        logic [3:0] commit_v;
        if (reset) begin
            q_raw.delete();
            for (int k = 0; k < SS; k++) q_raw.push_back(4'b0000);
            q_c.delete();
            m_lvl  = 4'b0000;
            m_rise = 4'b0000;
            m_fall = 4'b0000;
        end else begin
            q_raw.push_back(raw_in);
            c = q_raw.pop_front() ^ INV;
            q_c.push_back(c);
            if (q_c.size() > DC) void'(q_c.pop_front());
            for (int i = 0; i < NCH; i++) begin
                commit_v[i] = (q_c.size() == DC);
                for (int j = 0; j < q_c.size(); j++) begin
                    e = q_c[j];
                    if (e[i] == m_lvl[i]) commit_v[i] = 1'b0;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (clr_valid && clr_mask[i]) begin
                    m_rise[i] = 1'b0;
                    m_fall[i] = 1'b0;
                end
                if (commit_v[i]) begin
                    m_lvl[i] = c[i];
                    if (c[i]) m_rise[i] = 1'b1;
                    else      m_fall[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_level", level_out, m_lvl);
        chk("model_rise", rise_pending, m_rise);
        chk("model_fall", fall_pending, m_fall);
        chk("model_irq", {3'b000, irq}, {3'b000, |(m_rise | m_fall)});
    endtask

    task automatic chk_all(input string tag, input logic [3:0] lvl, input logic [3:0] rise,
                           input logic [3:0] fall, input logic irq_exp);
        chk({tag, "_level"}, level_out, lvl);
        chk({tag, "_rise"}, rise_pending, rise);
        chk({tag, "_fall"}, fall_pending, fall);
        chk({tag, "_irq"}, {3'b000, irq}, {3'b000, irq_exp});
    endtask

    initial begin
        //          raw      rst   cv    cm       n   each  lvl      rise     fall     irq
        vecs[0] = '{4'b1000, 1'b1, 1'b0, 4'b0000, 3,  1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[1] = '{4'b1000, 1'b0, 1'b0, 4'b0000, 20, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[2] = '{4'b1001, 1'b0, 1'b0, 4'b0000, 9,  1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[3] = '{4'b1001, 1'b0, 1'b0, 4'b0000, 1,  1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1};
        vecs[4] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 9,  1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1};
        vecs[5] = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1,  1'b0, 4'b1001, 4'b1001, 4'b0000, 1'b1};
        vecs[6] = '{4'b1001, 1'b0, 1'b0, 4'b0000, 10, 1'b0, 4'b0001, 4'b1001, 4'b1000, 1'b1};
        vecs[7] = '{4'b1001, 1'b0, 1'b0, 4'b1111, 2,  1'b0, 4'b0001, 4'b1001, 4'b1000, 1'b1};
        vecs[8] = '{4'b1001, 1'b0, 1'b1, 4'b1000, 1,  1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1};

        reset     = 1'b1;
        raw_in    = 4'b1000;
        clr_valid = 1'b0;
        clr_mask  = 4'b0000;
        for (int k = 0; k < SS; k++) q_raw.push_back(4'b0000);
        #1;

        // Reset idle, clean press, inverted channel both ways, ignored clear, masked clear.
        for (int r = 0; r < 9; r++) begin
            raw_in    = vecs[r].raw;
            reset     = vecs[r].rst;
            clr_valid = vecs[r].cv;
            clr_mask  = vecs[r].cm;
            for (int k = 0; k < vecs[r].n; k++) begin
                tick();
                if (vecs[r].each || k == vecs[r].n - 1) begin
                    chk_all($sformatf("row%0d", r), vecs[r].lvl, vecs[r].rise,
                            vecs[r].fall, vecs[r].irq);
                end
            end
        end

        // Bounce on channel 1: 3-cycle runs never commit, then a steady high commits once.
        clr_valid = 1'b0;
        clr_mask  = 4'b0000;
        raw_in    = 4'b1001;
        for (int t = 0; t < 30; t++) begin
            if (t % 3 == 0) raw_in[1] = ~raw_in[1];
            tick();
            chk("bounce_level", level_out, 4'b0001);
            chk("bounce_rise", rise_pending, 4'b0001);
        end
        raw_in[1] = 1'b1;
        repeat (9) tick();
        chk("hold_early_rise", rise_pending, 4'b0001);
        tick();
        chk("hold_commit_rise", rise_pending, 4'b0011);
        chk("hold_commit_level", level_out, 4'b0011);
        clr_valid = 1'b1;
        clr_mask  = 4'b0010;
        tick();
        clr_valid = 1'b0;
        chk("clr_ch1_rise", rise_pending, 4'b0001);

        // Clear race: clear channel 0 on the very edge its fall commits.
        raw_in[0] = 1'b0;
        repeat (9) tick();
        chk("race_pre_level", level_out, 4'b0011);
        chk("race_pre_fall", fall_pending, 4'b0000);
        clr_valid = 1'b1;
        clr_mask  = 4'b0001;
        tick();
        chk_all("race", 4'b0010, 4'b0000, 4'b0001, 1'b1);
        tick();
        chk_all("race_clr2", 4'b0010, 4'b0000, 4'b0000, 1'b0);
        clr_valid = 1'b0;
        clr_mask  = 4'b0000;

        // Reset in the middle of a count discards it; a full window is needed afterwards.
        raw_in = 4'b1110;
        repeat (7) tick();
        chk("midcnt_level", level_out, 4'b0010);
        reset = 1'b1;
        tick();
        chk_all("midcnt_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        repeat (9) tick();
        chk_all("post_reset_early", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        tick();
        chk_all("post_reset_commit", 4'b0110, 4'b0110, 4'b0000, 1'b1);

        // Randomized run: slow random pin changes, random clears, rare resets.
        for (int t = 0; t < 3000; t++) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 9) == 0) raw_in[i] = ~raw_in[i];
            end
            clr_valid = ($urandom_range(0, 15) == 0);
            clr_mask  = 4'($urandom_range(0, 15));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
